// File: rtl/seq_digit_adder.sv
// Multi-cycle add/subtract unit: a DIGIT-bit ripple slice processes WIDTH-bit operands
// one digit per clock, LSB first, with a registered carry between digits and a start/done handshake.
module seq_digit_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;

  logic [WIDTH-1:0] r_a, r_b, r_sum;
  logic             r_carry, r_cout, r_ovf;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT-1:0] w_ds;
  logic [DIGIT:0]   w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_nx;

  // Operands shift right each digit so the slice always sees the low DIGIT bits.
  assign w_c[0] = r_carry;
  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    logic w_hs, w_hc0, w_hc1;
    assign w_hs     = r_a[g] ^ r_b[g];
    assign w_hc0    = r_a[g] & r_b[g];
    assign w_ds[g]  = w_hs ^ w_c[g];
    assign w_hc1    = w_hs & w_c[g];
    assign w_c[g+1] = w_hc0 | w_hc1;
  end

  // Result digits enter at the top; after NDIG shifts digit 0 sits at the LSB.
  assign w_sum_nx = WIDTH'({w_ds, r_sum} >> DIGIT);
  assign w_last   = (r_cnt == CW'(NDIG - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_next = RUN;
      RUN:     if (w_last)  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_a     <= i_a;
          r_b     <= i_sub ? ~i_b : i_b;
          r_carry <= i_sub | i_cin;
          r_cnt   <= '0;
          r_sum   <= '0;
        end
        RUN: begin
          r_a     <= r_a >> DIGIT;
          r_b     <= r_b >> DIGIT;
          r_sum   <= w_sum_nx;
          r_carry <= w_c[DIGIT];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_cout <= w_c[DIGIT];
            r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy     = (r_state == RUN);
  assign o_done     = (r_state == DONE);
  assign o_sum      = r_sum;
  assign o_cout     = r_cout;
  assign o_overflow = r_ovf;
endmodule

// File: tb/tb_seq_digit_adder.sv
// Directed and random checks of seq_digit_adder at DIGIT = 1, 4 and 16 (WIDTH = 16),
// all three instances driven from the same stimulus.
module tb_seq_digit_adder;
  logic clk = 1'b0;
  logic rst, start, sub, cin;
  logic [15:0] a, b;
  logic [2:0] busy, done, cout, ovf;
  logic [2:0][15:0] sum;

  int nerr = 0, nchk = 0;
  int lat [3];
  int nbusy4, ndone4;

  always #5 clk = ~clk;

  seq_digit_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub), .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy[0]), .o_done(done[0]), .o_sum(sum[0]), .o_cout(cout[0]), .o_overflow(ovf[0]));
  seq_digit_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub), .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy[1]), .o_done(done[1]), .o_sum(sum[1]), .o_cout(cout[1]), .o_overflow(ovf[1]));
  seq_digit_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sub(sub), .i_a(a), .i_b(b), .i_cin(cin),
    .o_busy(busy[2]), .o_done(done[2]), .o_sum(sum[2]), .o_cout(cout[2]), .o_overflow(ovf[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // {overflow, cout, sum}; overflow from operand/result signs
  function automatic logic [17:0] model(input logic [15:0] ma, mb, input logic ms, mc);
    logic [15:0] bb;
    logic [16:0] r;
    logic        v;
    bb = ms ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, bb} + {16'd0, (ms ? 1'b1 : mc)};
    v  = (ma[15] == bb[15]) && (r[15] != ma[15]);
    return {v, r};
  endfunction

  task automatic do_op(input logic [15:0] ta, tb, input logic ts, tc, input bit noise);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) lat[i] = 0;
    nbusy4 = 0; ndone4 = 0;
    for (int c = 1; c <= 40 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0); c++) begin
      if (busy[1]) nbusy4++;
      if (noise && busy[1]) begin
        start = $urandom_range(0, 1);
        a = 16'($urandom); b = 16'($urandom);
        sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
      end else begin
        start = 1'b0;
      end
      tick();
      for (int i = 0; i < 3; i++) if (done[i] && lat[i] == 0) lat[i] = c;
      if (done[1]) ndone4++;
    end
    start = 1'b0;
    tick();
  endtask

  task automatic chk_all(input string tag, input logic [15:0] ta, tb, input logic ts, tc);
    logic [17:0] e;
    e = model(ta, tb, ts, tc);
    check({tag, " d1"},  {14'd0, ovf[0], cout[0], sum[0]}, {14'd0, e});
    check({tag, " d4"},  {14'd0, ovf[1], cout[1], sum[1]}, {14'd0, e});
    check({tag, " d16"}, {14'd0, ovf[2], cout[2], sum[2]}, {14'd0, e});
    check({tag, " lat1"},  lat[0], 16);
    check({tag, " lat4"},  lat[1], 4);
    check({tag, " lat16"}, lat[2], 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset flags %0d", i), {28'd0, busy[i], done[i], cout[i], ovf[i]}, 0);
      check($sformatf("reset sum %0d", i), {16'd0, sum[i]}, 0);
    end

    // carry out of MSB, busy width, single done pulse
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("t1 sum", {16'd0, sum[1]}, 32'h0000);
    check("t1 cout/ovf", {30'd0, cout[1], ovf[1]}, 32'b10);
    check("t1 busy cycles", nbusy4, 4);
    check("t1 done pulses", ndone4, 1);
    chk_all("t1", 16'hFFFF, 16'h0001, 1'b0, 1'b0);

    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("t2a sum", {16'd0, sum[1]}, 32'h8000);
    check("t2a cout/ovf", {30'd0, cout[1], ovf[1]}, 32'b01);
    chk_all("t2a", 16'h7FFF, 16'h0001, 1'b0, 1'b0);

    do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    check("t2b sum", {16'd0, sum[1]}, 32'h7FFF);
    check("t2b cout/ovf", {30'd0, cout[1], ovf[1]}, 32'b11);
    chk_all("t2b", 16'h8000, 16'h0001, 1'b1, 1'b0);

    do_op(16'h0003, 16'h0005, 1'b1, 1'b1, 1'b0);
    check("t3a sum", {16'd0, sum[1]}, 32'hFFFE);
    check("t3a cout/ovf", {30'd0, cout[1], ovf[1]}, 32'b00);
    chk_all("t3a", 16'h0003, 16'h0005, 1'b1, 1'b1);

    do_op(16'h1234, 16'h0001, 1'b0, 1'b1, 1'b0);
    check("t3b sum", {16'd0, sum[1]}, 32'h1236);
    chk_all("t3b", 16'h1234, 16'h0001, 1'b0, 1'b1);

    // inputs churn during RUN; only the DIGIT=4 unit is judged here
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    check("t4 sum", {16'd0, sum[1]}, 32'h3333);
    check("t4 cout/ovf", {30'd0, cout[1], ovf[1]}, 32'b00);
    check("t4 done pulses", ndone4, 1);
    check("t4 lat4", lat[1], 4);

    // reset in the second RUN cycle
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5 flags", {28'd0, busy[1], done[1], cout[1], ovf[1]}, 0);
    check("t5 sum", {16'd0, sum[1]}, 0);
    check("t5 d1 busy", {31'd0, busy[0]}, 0);
    ndone4 = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done[1]) ndone4++;
    end
    check("t5 no done", ndone4, 0);
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    check("t5 sum after", {16'd0, sum[1]}, 32'hFFFE);
    check("t5 cout after", {31'd0, cout[1]}, 1);
    chk_all("t5", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      logic [15:0] ra, rb;
      logic rs, rc;
      ra = 16'($urandom); rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      do_op(ra, rb, rs, rc, 1'b0);
      chk_all($sformatf("rnd%0d", n), ra, rb, rs, rc);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
